// File: rtl/full_adder_cell.sv
// Bank of independent 1-bit full adders. Each lane has combinational outputs
// for same-cycle ripple chains and registered outputs with a valid flag.
module full_adder_cell #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] cin,
  output logic [WIDTH-1:0] sum_c,
  output logic [WIDTH-1:0] cout_c,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] cout,
  output logic             out_valid
);

  // Bitwise operators keep every lane independent; no carry crosses lanes.
  always_comb begin
    sum_c  = a ^ b ^ cin;
    cout_c = (a & b) | (a & cin) | (b & cin);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum       <= '0;
      cout      <= '0;
      out_valid <= 1'b0;
    end else begin
      if (in_valid) begin
        sum  <= sum_c;
        cout <= cout_c;
      end
      out_valid <= in_valid;
    end
  end

endmodule

// File: tb/tb_full_adder_cell.sv
// Self-checking bench for full_adder_cell: single-lane, 4-lane and a 4-stage
// ripple chain, each compared against plain-arithmetic reference values.
module tb_full_adder_cell;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // Single-lane instance
  logic       v1;
  logic [0:0] a1, b1, c1;
  wire  [0:0] s1c, co1c, s1, co1;
  wire        ov1;

  full_adder_cell #(.WIDTH(1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .a(a1), .b(b1), .cin(c1),
    .sum_c(s1c), .cout_c(co1c), .sum(s1), .cout(co1), .out_valid(ov1)
  );

  // Four-lane instance
  logic       v4;
  logic [3:0] a4, b4, c4;
  wire  [3:0] s4c, co4c, s4, co4;
  wire        ov4;

  full_adder_cell #(.WIDTH(4)) u4 (
    .clk(clk), .rst_n(rst_n), .in_valid(v4), .a(a4), .b(b4), .cin(c4),
    .sum_c(s4c), .cout_c(co4c), .sum(s4), .cout(co4), .out_valid(ov4)
  );

  // Ripple chain of four single-lane instances
  logic       vr;
  logic [3:0] ra, rb;
  logic       rcin;
  wire  [4:0] carry;
  wire  [3:0] rsc, rs, rco, rov;
  assign carry[0] = rcin;

  for (genvar i = 0; i < 4; i++) begin : g_rip
    full_adder_cell #(.WIDTH(1)) u_r (
      .clk(clk), .rst_n(rst_n), .in_valid(vr),
      .a(ra[i:i]), .b(rb[i:i]), .cin(carry[i:i]),
      .sum_c(rsc[i:i]), .cout_c(carry[i+1:i+1]),
      .sum(rs[i:i]), .cout(rco[i:i]), .out_valid(rov[i])
    );
  end

  int total  = 0;
  int passed = 0;

  // Reference state for the registered outputs of u1 and u4
  logic       e1s, e1c, e1v;
  logic [3:0] e4s, e4c;
  logic       e4v;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [1:0] add3(input logic x, input logic y, input logic z);
    int t;
    t = int'(x) + int'(y) + int'(z);
    return t[1:0];
  endfunction

  // Called at posedge+1: drive, check comb, clock, check registered.
  task automatic step1(input logic va, input logic vb, input logic vc, input logic vv,
                       input string tag);
    logic [1:0] r;
    a1 = va; b1 = vb; c1 = vc; v1 = vv;
    r = add3(va, vb, vc);
    #1;
    check({tag, "_sum_c"},  {7'd0, s1c},  {7'd0, r[0]});
    check({tag, "_cout_c"}, {7'd0, co1c}, {7'd0, r[1]});
    @(posedge clk);
    #1;
    if (rst_n) begin
      if (vv) begin e1s = r[0]; e1c = r[1]; end
      e1v = vv;
    end
    check({tag, "_sum"},   {7'd0, s1},  {7'd0, e1s});
    check({tag, "_cout"},  {7'd0, co1}, {7'd0, e1c});
    check({tag, "_valid"}, {7'd0, ov1}, {7'd0, e1v});
  endtask

  task automatic step4(input logic [3:0] va, input logic [3:0] vb, input logic [3:0] vc,
                       input logic vv, input string tag);
    logic [3:0] es, ec;
    logic [1:0] r;
    a4 = va; b4 = vb; c4 = vc; v4 = vv;
    for (int i = 0; i < 4; i++) begin
      r = add3(va[i], vb[i], vc[i]);
      es[i] = r[0];
      ec[i] = r[1];
    end
    #1;
    check({tag, "_sum_c"},  {4'd0, s4c},  {4'd0, es});
    check({tag, "_cout_c"}, {4'd0, co4c}, {4'd0, ec});
    @(posedge clk);
    #1;
    if (vv) begin e4s = es; e4c = ec; end
    e4v = vv;
    check({tag, "_sum"},   {4'd0, s4},  {4'd0, e4s});
    check({tag, "_cout"},  {4'd0, co4}, {4'd0, e4c});
    check({tag, "_valid"}, {7'd0, ov4}, {7'd0, e4v});
  endtask

  task automatic stepr(input logic [3:0] va, input logic [3:0] vb, input logic vc,
                       input string tag);
    int t;
    logic [4:0] e;
    ra = va; rb = vb; rcin = vc; vr = 1'b1;
    t = int'(va) + int'(vb) + int'(vc);
    e = t[4:0];
    #1;
    check({tag, "_sum_c"}, {4'd0, rsc},      {4'd0, e[3:0]});
    check({tag, "_carry"}, {7'd0, carry[4]}, {7'd0, e[4]});
    @(posedge clk);
    #1;
    check({tag, "_sum"},  {4'd0, rs},      {4'd0, e[3:0]});
    check({tag, "_cout"}, {7'd0, rco[3]},  {7'd0, e[4]});
    check({tag, "_valid"}, {4'd0, rov},    8'h0f);
  endtask

  initial begin
    rst_n = 1'b0;
    v1 = 1'b0; a1 = '0; b1 = '0; c1 = '0;
    v4 = 1'b0; a4 = '0; b4 = '0; c4 = '0;
    vr = 1'b0; ra = '0; rb = '0; rcin = 1'b0;
    e1s = 1'b0; e1c = 1'b0; e1v = 1'b0;
    e4s = '0;   e4c = '0;   e4v = 1'b0;

    // Reset state
    #12;
    check("rst_sum1",   {7'd0, s1},  8'h00);
    check("rst_cout1",  {7'd0, co1}, 8'h00);
    check("rst_valid1", {7'd0, ov1}, 8'h00);
    check("rst_sum4",   {4'd0, s4},  8'h00);
    check("rst_valid4", {7'd0, ov4}, 8'h00);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Exhaustive truth table
    for (int k = 0; k < 8; k++) begin
      logic [2:0] kv;
      kv = 3'(k);
      step1(kv[2], kv[1], kv[0], 1'b1, $sformatf("tt%0d", k));
    end

    // Hold: capture (1,0,1), then in_valid=0 with changed inputs
    step1(1'b1, 1'b0, 1'b1, 1'b1, "hold_cap");
    step1(1'b0, 1'b1, 1'b0, 1'b0, "hold");
    check("hold_sum_lit",  {7'd0, s1},  8'h00);
    check("hold_cout_lit", {7'd0, co1}, 8'h01);

    // Asynchronous reset between edges
    step1(1'b1, 1'b1, 1'b0, 1'b1, "ar_cap");
    #2;
    rst_n = 1'b0;
    e1s = 1'b0; e1c = 1'b0; e1v = 1'b0;
    #1;
    check("ar_sum",   {7'd0, s1},  8'h00);
    check("ar_cout",  {7'd0, co1}, 8'h00);
    check("ar_valid", {7'd0, ov1}, 8'h00);
    @(posedge clk);
    #1;
    check("ar_held_cout", {7'd0, co1}, 8'h00);
    rst_n = 1'b1;
    a1 = 1'b1; b1 = 1'b0; c1 = 1'b0; v1 = 1'b1;
    #2;
    check("ar_nocap_sum",   {7'd0, s1},  8'h00);
    check("ar_nocap_valid", {7'd0, ov1}, 8'h00);
    @(posedge clk);
    #1;
    check("ar_first_sum",   {7'd0, s1},  8'h01);
    check("ar_first_valid", {7'd0, ov1}, 8'h01);
    e1s = 1'b1; e1c = 1'b0; e1v = 1'b1;

    // Back-to-back streaming
    step1(1'b1, 1'b0, 1'b0, 1'b1, "bb0");
    step1(1'b0, 1'b1, 1'b1, 1'b1, "bb1");
    step1(1'b1, 1'b1, 1'b1, 1'b1, "bb2");

    // Random single lane
    for (int k = 0; k < 40; k++) begin
      logic [3:0] rv;
      rv = 4'($urandom);
      step1(rv[0], rv[1], rv[2], rv[3], $sformatf("r1_%0d", k));
    end
    v1 = 1'b0;

    // Multi-lane
    step4(4'b1111, 4'b1100, 4'b0000, 1'b1, "w4");
    check("w4_sum_lit",  {4'd0, s4},  8'h03);
    check("w4_cout_lit", {4'd0, co4}, 8'h0c);
    for (int k = 0; k < 30; k++) begin
      step4(4'($urandom), 4'($urandom), 4'($urandom), 1'($urandom),
            $sformatf("r4_%0d", k));
    end
    v4 = 1'b0;

    // Ripple chain
    stepr(4'b1011, 4'b1101, 1'b0, "rip");
    check("rip_sum_lit", {4'd0, rsc},      8'h08);
    check("rip_co_lit",  {7'd0, carry[4]}, 8'h01);
    for (int k = 0; k < 30; k++) begin
      stepr(4'($urandom), 4'($urandom), 1'($urandom), $sformatf("rr_%0d", k));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
